// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the EX-stage multiply/divide sequencer.
// Op codes, FSM state codes and the divide-by-zero quotient.
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [63:0] DIV0_QUOT = '1;

    // Odd encodings are the unsigned variants.
    function automatic logic is_signed(input logic [1:0] op);
        return !op[0];
    endfunction

endpackage

// File: rtl/udiv_iter.sv
// udiv_iter: unsigned radix-2 restoring divider datapath, one step per cycle.
// o_quot/o_rem show the result of the step taken on the current cycle.
module udiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fit;

    // Dividend bits stream out of the top of r_quot as quotient bits enter.
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};
    assign w_fit   = !w_trial[WIDTH];

    assign o_quot = {r_quot[WIDTH-2:0], w_fit};
    assign o_rem  = w_fit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_last = (r_cnt == CW'(WIDTH-1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_rem  <= '0;
            r_quot <= i_dividend;
            r_dvs  <= i_divisor;
            r_cnt  <= '0;
        end else if (i_step) begin
            r_rem  <= o_rem;
            r_quot <= o_quot;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage MULT/MULTU/DIV/DIVU sequencer with pipeline stall.
// Returns {hi, lo} for the HILO write; holds it while EX is frozen.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             ex_hold,
    output logic             stall,
    output logic             busy,
    output logic             res_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]         r_state;
    logic               r_sgn;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_sgn;
    logic               w_step;
    logic               w_last;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept = (r_state == S_IDLE) & req_valid & !flush;
    assign w_sgn    = is_signed(req_op);
    assign w_step   = (r_state == S_DIV) & !flush;

    assign w_mag_a = (w_sgn & op_a[WIDTH-1]) ? -op_a : op_a;
    assign w_mag_b = (w_sgn & op_b[WIDTH-1]) ? -op_b : op_b;

    assign w_ext_a = r_sgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_ext_b = r_sgn ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    udiv_iter #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_accept & req_op[1]),
        .i_step     (w_step),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_sgn   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_sgn   <= w_sgn;
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_neg_q <= w_sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        r_neg_r <= w_sgn & op_a[WIDTH-1];
                        if (!req_op[1]) begin
                            r_state <= S_MUL;
                        end else if (op_b == '0) begin
                            r_state <= S_DONE;
                            r_hi    <= op_a;
                            r_lo    <= DIV0_QUOT[WIDTH-1:0];
                        end else begin
                            r_state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    r_hi    <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo    <= w_prod[WIDTH-1:0];
                    r_state <= S_DONE;
                end
                S_DIV: begin
                    // MIN/-1 needs no special case: the negated quotient wraps to MIN.
                    if (w_last) begin
                        r_hi    <= r_neg_r ? -w_rem : w_rem;
                        r_lo    <= r_neg_q ? -w_quot : w_quot;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!ex_hold) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall     = req_valid & !flush & (r_state != S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign res_valid = (r_state == S_DONE);
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and random checks of muldiv_ctrl against an
// arithmetic reference model (64-bit integer multiply/divide).
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        ex_hold;
    logic        stall;
    logic        busy;
    logic        res_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_op    (req_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .ex_hold   (ex_hold),
        .stall     (stall),
        .busy      (busy),
        .res_valid (res_valid),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'd0: return 64'(sa * sb);
            2'd1: return ua * ub;
            2'd2: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int exp_stalls(input logic [1:0] op, input logic [31:0] b);
        if (!op[1]) return 2;
        if (b == 0) return 1;
        return 33;
    endfunction

    // Issue one request; return at the first DONE cycle (sampled on negedge).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag,
                          output logic [63:0] exp);
        int st;
        int guard;
        exp = model(op, a, b);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        op_a      = a;
        op_b      = b;
        st        = 0;
        guard     = 0;
        @(negedge clk);
        if (stall) st++;
        @(posedge clk); #1;
        op_a = $urandom;
        op_b = $urandom;
        @(negedge clk);
        while (!res_valid && guard < 100) begin
            if (stall) st++;
            guard++;
            @(negedge clk);
        end
        check({tag, "_done"}, 64'(res_valid), 64'd1);
        check({tag, "_stalls"}, 64'(st), 64'(exp_stalls(op, b)));
        check({tag, "_done_stall"}, 64'(stall), 64'd0);
        check({tag, "_res"}, {hi, lo}, exp);
    endtask

    task automatic finish_op();
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    logic [63:0] res;
    logic [63:0] kept;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          seen;

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        op_a      = '0;
        op_b      = '0;
        flush     = 1'b0;
        ex_hold   = 1'b0;
        #2;
        check("reset_outs", {61'b0, stall, busy, res_valid}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(2'd0, 32'hFFFFFFFD, 32'd7, "mult", res);
        check("mult_const", res, 64'hFFFFFFFF_FFFFFFEB);
        finish_op();
        run_op(2'd1, 32'hFFFFFFFD, 32'd7, "multu", res);
        check("multu_const", res, 64'h00000006_FFFFFFEB);
        finish_op();
        run_op(2'd2, 32'hFFFFFFF9, 32'd2, "div", res);
        check("div_const", res, 64'hFFFFFFFF_FFFFFFFD);
        finish_op();
        run_op(2'd3, 32'd100, 32'd7, "divu", res);
        check("divu_const", res, 64'h00000002_0000000E);
        finish_op();
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf", res);
        check("div_ovf_const", res, 64'h00000000_80000000);
        finish_op();
        run_op(2'd3, 32'd5, 32'd0, "divu_zero", res);
        check("divu_zero_const", res, 64'h00000005_FFFFFFFF);
        finish_op();

        // Flush mid-divide at iteration 10.
        kept = {hi, lo};
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'd2; op_a = 32'd1000; op_b = 32'd7;
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check("flush_stall", 64'(stall), 64'd0);
        check("flush_busy_before", 64'(busy), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_idle", 64'(busy), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check("flush_no_valid", 64'(seen), 64'd0);
        check("flush_hilo_kept", {hi, lo}, kept);

        // Flush wins over acceptance in IDLE.
        @(posedge clk); #1;
        req_valid = 1'b1; flush = 1'b1; req_op = 2'd0;
        @(negedge clk);
        check("flush_prio_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_prio_busy", 64'(busy), 64'd0);

        run_op(2'd3, 32'd9, 32'd3, "divu_after_flush", res);
        check("divu_9_3_const", res, 64'h00000000_00000003);
        finish_op();

        // Hold in DONE, then release.
        ex_hold = 1'b1;
        run_op(2'd0, 32'd11, 32'hFFFFFFF3, "hold", res);
        repeat (4) begin
            @(posedge clk); #1;
            op_a = $urandom;
            op_b = $urandom;
            @(negedge clk);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_hilo", {hi, lo}, res);
        end
        @(posedge clk); #1;
        ex_hold = 1'b0;
        @(negedge clk);
        check("hold_release_valid", 64'(res_valid), 64'd1);
        finish_op();
        check("hold_after_valid", 64'(res_valid), 64'd0);
        check("hold_after_hilo", {hi, lo}, res);

        // Flush while in DONE.
        ex_hold = 1'b1;
        run_op(2'd3, 32'd77, 32'd10, "done_flush", res);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("done_flush_valid_now", 64'(res_valid), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0; ex_hold = 1'b0;
        @(negedge clk);
        check("done_flush_valid_next", 64'(res_valid), 64'd0);
        check("done_flush_hilo", {hi, lo}, res);

        // Random operations.
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            run_op(rop, ra, rb, $sformatf("rnd%0d", i), res);
            finish_op();
        end

        // Reset mid-divide.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'd2; op_a = 32'd1000; op_b = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0; req_valid = 1'b0;
        #1;
        check("rst_mid_outs", {61'b0, stall, busy, res_valid}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op(2'd1, 32'd2, 32'd3, "multu_after_rst", res);
        check("multu_2_3_const", res, 64'd6);
        finish_op();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
